// File: rtl/map_table_rollback_ctrl_pkg.sv
// Shared types for the map-table rollback controller: index/tag widths, FSM states, undo-log entry.
// No logic, no latency, no backpressure.
package map_table_rollback_ctrl_pkg;

    localparam int ROB_SZ      = 32;
    localparam int ARCH_REG_SZ = 32;
    localparam int PHYS_REG_SZ = 64;

    localparam int ROB_IDX_W = $clog2(ROB_SZ);
    localparam int AREG_W    = $clog2(ARCH_REG_SZ);
    localparam int TAG_W     = $clog2(PHYS_REG_SZ);

    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [AREG_W-1:0]    areg_t;

    typedef enum logic [1:0] {
        MT_IDLE,
        MT_WALK,
        MT_DONE
    } mt_state_e;

    typedef struct packed {
        logic  has_dest;
        areg_t areg;
        tag_t  told;
    } undo_entry_t;

endpackage

// File: rtl/map_table_rollback_ctrl_if.sv
// Bundle of dispatch, CDB, squash inputs and map-table write/ready outputs of the rollback controller.
// No logic, no latency; stall is reported through dispatch_stall.
interface map_table_rollback_ctrl_if;
    import map_table_rollback_ctrl_pkg::*;

    logic     dispatch_valid;
    logic     dispatch_has_dest;
    rob_idx_t dispatch_rob_idx;
    areg_t    dispatch_areg;
    tag_t     dispatch_t;
    tag_t     dispatch_told;
    logic     cdb_valid;
    tag_t     cdb_tag;
    logic     squash_valid;
    rob_idx_t squash_br_idx;
    rob_idx_t squash_tail;

    logic     dispatch_stall;
    logic     mt_wr_valid;
    areg_t    mt_wr_reg;
    tag_t     mt_wr_tag;
    logic     mt_wr_restore;
    logic     mt_rdy_valid;
    tag_t     mt_rdy_tag;
    logic     rollback_busy;
    logic     rollback_done;

    modport master (
        output dispatch_valid, dispatch_has_dest, dispatch_rob_idx, dispatch_areg,
               dispatch_t, dispatch_told, cdb_valid, cdb_tag,
               squash_valid, squash_br_idx, squash_tail,
        input  dispatch_stall, mt_wr_valid, mt_wr_reg, mt_wr_tag, mt_wr_restore,
               mt_rdy_valid, mt_rdy_tag, rollback_busy, rollback_done
    );

    modport slave (
        input  dispatch_valid, dispatch_has_dest, dispatch_rob_idx, dispatch_areg,
               dispatch_t, dispatch_told, cdb_valid, cdb_tag,
               squash_valid, squash_br_idx, squash_tail,
        output dispatch_stall, mt_wr_valid, mt_wr_reg, mt_wr_tag, mt_wr_restore,
               mt_rdy_valid, mt_rdy_tag, rollback_busy, rollback_done
    );

endinterface

// File: rtl/map_table_rollback_ctrl_undo_log.sv
// Per-ROB-slot undo log {has_dest, areg, told}: one write port, one async read port with clear strobe.
// Write lands at the clock edge, read is combinational; no backpressure.
module map_table_rollback_ctrl_undo_log
    import map_table_rollback_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  rob_idx_t    wr_idx,
    input  undo_entry_t wr_entry,
    input  rob_idx_t    rd_idx,
    input  logic        rd_clr,
    output undo_entry_t rd_entry
);

    undo_entry_t mem [ROB_SZ];

    // Writes (dispatch, IDLE only) and clears (walk) never coincide.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROB_SZ; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= wr_entry;
            end
            if (rd_clr) begin
                mem[rd_idx].has_dest <= 1'b0;
            end
        end
    end

    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/map_table_rollback_ctrl.sv
// Muxes map-table write port between dispatch rename and youngest-first squash rollback.
// Rename write is same-cycle; rollback takes one cycle per squashed slot plus a done cycle; dispatch stalled meanwhile.
module map_table_rollback_ctrl
    import map_table_rollback_ctrl_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    map_table_rollback_ctrl_if.slave  bus
);

    mt_state_e   state, state_nx;
    rob_idx_t    ptr, ptr_nx;
    rob_idx_t    count, count_nx;
    logic        walk_clr;
    logic        disp_go;
    undo_entry_t rd_entry;
    undo_entry_t wr_entry;

    // Squash wins over a dispatch presented in the same cycle.
    assign disp_go  = (state == MT_IDLE) && !bus.squash_valid && bus.dispatch_valid;
    assign wr_entry = '{has_dest: bus.dispatch_has_dest,
                        areg:     bus.dispatch_areg,
                        told:     bus.dispatch_told};

    map_table_rollback_ctrl_undo_log u_undo_log (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (disp_go),
        .wr_idx   (bus.dispatch_rob_idx),
        .wr_entry (wr_entry),
        .rd_idx   (ptr),
        .rd_clr   (walk_clr),
        .rd_entry (rd_entry)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= MT_IDLE;
            ptr   <= '0;
            count <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            count <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        count_nx = count;
        walk_clr = 1'b0;
        case (state)
            MT_IDLE: begin
                if (bus.squash_valid) begin
                    ptr_nx   = bus.squash_tail - 1'b1;
                    count_nx = bus.squash_tail - bus.squash_br_idx - 1'b1;
                    state_nx = (count_nx != '0) ? MT_WALK : MT_DONE;
                end
            end
            MT_WALK: begin
                walk_clr = 1'b1;
                ptr_nx   = ptr - 1'b1;
                count_nx = count - 1'b1;
                if (count == rob_idx_t'(1)) begin
                    state_nx = MT_DONE;
                end
            end
            MT_DONE: begin
                state_nx = MT_IDLE;
            end
            default: begin
                state_nx = MT_IDLE;
            end
        endcase
    end

    // Every output is forced low while reset is held, even the combinational paths.
    always_comb begin
        bus.mt_wr_valid   = 1'b0;
        bus.mt_wr_reg     = '0;
        bus.mt_wr_tag     = '0;
        bus.mt_wr_restore = 1'b0;
        if (reset) begin
            if (state == MT_WALK && rd_entry.has_dest) begin
                bus.mt_wr_valid   = 1'b1;
                bus.mt_wr_reg     = rd_entry.areg;
                bus.mt_wr_tag     = rd_entry.told;
                bus.mt_wr_restore = 1'b1;
            end else if (disp_go && bus.dispatch_has_dest) begin
                bus.mt_wr_valid   = 1'b1;
                bus.mt_wr_reg     = bus.dispatch_areg;
                bus.mt_wr_tag     = bus.dispatch_t;
            end
        end
    end

    assign bus.dispatch_stall = reset && (bus.squash_valid || (state != MT_IDLE));
    assign bus.mt_rdy_valid   = reset && bus.cdb_valid;
    assign bus.mt_rdy_tag     = reset ? bus.cdb_tag : '0;
    assign bus.rollback_busy  = (state != MT_IDLE);
    assign bus.rollback_done  = (state == MT_DONE);

endmodule

// File: tb/tb_map_table_rollback_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus random traffic against a schedule-queue model.
module tb_map_table_rollback_ctrl;
    import map_table_rollback_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    map_table_rollback_ctrl_if bus ();

    map_table_rollback_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Model: undo log as a plain array, pending rollback as a queue of slots (-1 = done cycle).
    undo_entry_t mlog [ROB_SZ];
    int          sched [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        int e_stall, e_wv, e_reg, e_tag, e_rest, e_rv, e_rt, e_busy, e_done, cnt;
        e_stall = 0; e_wv = 0; e_reg = 0; e_tag = 0; e_rest = 0;
        e_busy = 0; e_done = 0;
        e_rv = (reset && bus.cdb_valid) ? 1 : 0;
        e_rt = reset ? int'(bus.cdb_tag) : 0;
        if (reset) begin
            if (sched.size() != 0) begin
                assert (!bus.squash_valid) else $error("squash_valid driven while rollback busy");
                e_busy = 1;
                e_stall = 1;
                if (sched[0] < 0) begin
                    e_done = 1;
                end else if (mlog[sched[0]].has_dest) begin
                    e_wv = 1; e_rest = 1;
                    e_reg = int'(mlog[sched[0]].areg);
                    e_tag = int'(mlog[sched[0]].told);
                end
            end else begin
                e_stall = bus.squash_valid ? 1 : 0;
                if (!bus.squash_valid && bus.dispatch_valid && bus.dispatch_has_dest) begin
                    e_wv = 1;
                    e_reg = int'(bus.dispatch_areg);
                    e_tag = int'(bus.dispatch_t);
                end
            end
        end

        chk("stall", int'(bus.dispatch_stall), e_stall);
        chk("wr_valid", int'(bus.mt_wr_valid), e_wv);
        if (e_wv == 1) begin
            chk("wr_reg", int'(bus.mt_wr_reg), e_reg);
            chk("wr_tag", int'(bus.mt_wr_tag), e_tag);
            chk("wr_restore", int'(bus.mt_wr_restore), e_rest);
        end
        chk("rdy_valid", int'(bus.mt_rdy_valid), e_rv);
        chk("rdy_tag", int'(bus.mt_rdy_tag), e_rt);
        chk("busy", int'(bus.rollback_busy), e_busy);
        chk("done", int'(bus.rollback_done), e_done);

        if (!reset) begin
            for (int i = 0; i < ROB_SZ; i++) mlog[i] = '0;
            sched.delete();
        end else if (sched.size() != 0) begin
            if (sched[0] >= 0) mlog[sched[0]].has_dest = 1'b0;
            void'(sched.pop_front());
        end else if (bus.squash_valid) begin
            cnt = (int'(bus.squash_tail) - int'(bus.squash_br_idx) - 1) & (ROB_SZ - 1);
            for (int k = 0; k < cnt; k++) sched.push_back((int'(bus.squash_tail) - 1 - k) & (ROB_SZ - 1));
            sched.push_back(-1);
        end else if (bus.dispatch_valid) begin
            mlog[bus.dispatch_rob_idx] = '{has_dest: bus.dispatch_has_dest,
                                           areg: bus.dispatch_areg, told: bus.dispatch_told};
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        bus.dispatch_valid = 0; bus.dispatch_has_dest = 0; bus.dispatch_rob_idx = '0;
        bus.dispatch_areg = '0; bus.dispatch_t = '0; bus.dispatch_told = '0;
        bus.cdb_valid = 0; bus.cdb_tag = '0;
        bus.squash_valid = 0; bus.squash_br_idx = '0; bus.squash_tail = '0;
    endtask

    task automatic disp(input int idx, input int hd, input int ar, input int t, input int told);
        bus.dispatch_valid = 1;
        bus.dispatch_has_dest = hd[0];
        bus.dispatch_rob_idx = rob_idx_t'(idx);
        bus.dispatch_areg = areg_t'(ar);
        bus.dispatch_t = tag_t'(t);
        bus.dispatch_told = tag_t'(told);
    endtask

    task automatic sq(input int br, input int tail);
        bus.squash_valid = 1;
        bus.squash_br_idx = rob_idx_t'(br);
        bus.squash_tail = rob_idx_t'(tail);
    endtask

    task automatic t3_dispatches();
        disp(0, 1, 1, 20, 10); cyc();
        disp(1, 1, 2, 21, 11); cyc();
        disp(2, 0, 3, 22, 12); cyc();
        disp(3, 1, 4, 23, 13); cyc();
        idle_in();
    endtask

    initial begin
        for (int i = 0; i < ROB_SZ; i++) mlog[i] = '0;
        idle_in();
        reset = 0;
        disp(7, 1, 5, 40, 5);
        bus.cdb_valid = 1; bus.cdb_tag = 7;
        #2;
        chk("rst_wr_valid", int'(bus.mt_wr_valid), 0);
        chk("rst_stall", int'(bus.dispatch_stall), 0);
        chk("rst_rdy_valid", int'(bus.mt_rdy_valid), 0);
        chk("rst_busy", int'(bus.rollback_busy), 0);
        cyc(); cyc();
        idle_in(); reset = 1; #1;
        chk("rel_stall", int'(bus.dispatch_stall), 0);

        cyc(); disp(3, 1, 5, 40, 5); #1;
        chk("t2_wv", int'(bus.mt_wr_valid), 1);
        chk("t2_reg", int'(bus.mt_wr_reg), 5);
        chk("t2_tag", int'(bus.mt_wr_tag), 40);
        chk("t2_rest", int'(bus.mt_wr_restore), 0);
        cyc(); idle_in();

        t3_dispatches();
        sq(0, 4); #1;
        chk("t3_n_stall", int'(bus.dispatch_stall), 1);
        chk("t3_n_wv", int'(bus.mt_wr_valid), 0);
        cyc(); idle_in(); #1;
        chk("t3_n1_wv", int'(bus.mt_wr_valid), 1);
        chk("t3_n1_reg", int'(bus.mt_wr_reg), 4);
        chk("t3_n1_tag", int'(bus.mt_wr_tag), 13);
        chk("t3_n1_rest", int'(bus.mt_wr_restore), 1);
        cyc(); disp(5, 1, 6, 30, 14); #1;
        chk("t3_n2_wv", int'(bus.mt_wr_valid), 0);
        chk("t3_n2_stall", int'(bus.dispatch_stall), 1);
        cyc(); idle_in(); #1;
        chk("t3_n3_reg", int'(bus.mt_wr_reg), 2);
        chk("t3_n3_tag", int'(bus.mt_wr_tag), 11);
        cyc(); #1;
        chk("t3_n4_done", int'(bus.rollback_done), 1);
        chk("t3_n4_stall", int'(bus.dispatch_stall), 1);
        cyc(); #1;
        chk("t3_n5_busy", int'(bus.rollback_busy), 0);
        chk("t3_n5_stall", int'(bus.dispatch_stall), 0);

        sq(5, 6); #1;
        chk("t4_n_stall", int'(bus.dispatch_stall), 1);
        cyc(); idle_in(); #1;
        chk("t4_n1_done", int'(bus.rollback_done), 1);
        chk("t4_n1_wv", int'(bus.mt_wr_valid), 0);
        cyc(); #1;
        chk("t4_n2_busy", int'(bus.rollback_busy), 0);

        disp(30, 1, 7, 40, 50); cyc();
        disp(31, 1, 8, 41, 51); cyc();
        disp(0, 1, 9, 42, 52); cyc();
        disp(1, 1, 10, 43, 53); cyc();
        idle_in(); sq(30, 2);
        cyc(); idle_in(); #1;
        chk("t5_n1_reg", int'(bus.mt_wr_reg), 10);
        chk("t5_n1_tag", int'(bus.mt_wr_tag), 53);
        cyc(); #1;
        chk("t5_n2_tag", int'(bus.mt_wr_tag), 52);
        cyc(); #1;
        chk("t5_n3_reg", int'(bus.mt_wr_reg), 8);
        chk("t5_n3_tag", int'(bus.mt_wr_tag), 51);
        cyc(); #1;
        chk("t5_n4_done", int'(bus.rollback_done), 1);
        cyc();

        t3_dispatches();
        sq(0, 4);
        cyc(); idle_in();
        cyc(); reset = 0; bus.cdb_valid = 1; bus.cdb_tag = 9; #1;
        chk("t6_rst_wv", int'(bus.mt_wr_valid), 0);
        chk("t6_rst_busy", int'(bus.rollback_busy), 0);
        chk("t6_rst_rdy", int'(bus.mt_rdy_valid), 0);
        cyc(); reset = 1; idle_in();
        cyc(); disp(0, 1, 1, 25, 17); #1;
        chk("t6_disp_wv", int'(bus.mt_wr_valid), 1);
        chk("t6_disp_tag", int'(bus.mt_wr_tag), 25);
        cyc(); idle_in(); sq(31, 1);
        cyc(); idle_in(); bus.cdb_valid = 1; bus.cdb_tag = 33; #1;
        chk("t6_walk_tag", int'(bus.mt_wr_tag), 17);
        chk("t6_walk_rdy", int'(bus.mt_rdy_valid), 1);
        chk("t6_walk_rdy_tag", int'(bus.mt_rdy_tag), 33);
        cyc(); idle_in();
        cyc(); sq(0, 4);
        cyc(); idle_in(); #1;
        chk("t6_cleared_wv", int'(bus.mt_wr_valid), 0);
        repeat (4) cyc();

        for (int n = 0; n < 3000; n++) begin
            idle_in();
            reset = ($urandom_range(0, 299) != 0);
            bus.cdb_valid = $urandom_range(0, 1);
            bus.cdb_tag = tag_t'($urandom);
            if ($urandom_range(0, 3) != 0)
                disp($urandom_range(0, ROB_SZ - 1), $urandom_range(0, 3) != 0,
                     $urandom_range(0, ARCH_REG_SZ - 1), $urandom_range(0, PHYS_REG_SZ - 1),
                     $urandom_range(0, PHYS_REG_SZ - 1));
            if (reset && sched.size() == 0 && $urandom_range(0, 11) == 0)
                sq($urandom_range(0, ROB_SZ - 1), $urandom_range(0, ROB_SZ - 1));
            cyc();
        end
        idle_in(); reset = 1;
        repeat (40) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
